// File: rtl/conv_sequencer.sv
// GPIO-driven sequencer for the convolution engine: loads line memories from
// processor pixel writes, launches the convolution and streams results back.
module conv_sequencer #(
    parameter int unsigned BIT_LEN    = 8,
    parameter int unsigned NB_ADDRESS = 10,
    parameter int unsigned NB_IMAGE   = 10,
    parameter int unsigned M_LEN      = 3,
    parameter int unsigned GPIO_D     = 32
) (
    input  logic                  CLK100MHZ,
    input  logic                  i_rst,
    input  logic [GPIO_D-1:0]     i_gpio,
    output logic [GPIO_D-1:0]     o_gpio,
    output logic [M_LEN-1:0]      o_we,
    output logic [NB_ADDRESS-1:0] o_wr_addr,
    output logic [BIT_LEN-1:0]    o_wr_data,
    output logic [NB_IMAGE-1:0]   o_img_len,
    output logic                  o_conv_start,
    input  logic                  i_conv_done,
    output logic [NB_ADDRESS-1:0] o_rd_addr,
    input  logic [BIT_LEN-1:0]    i_rd_data,
    output logic [3:0]            o_led
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned TGT_W  = (M_LEN > 1) ? $clog2(M_LEN) : 1;
    localparam int unsigned HIGH_W = GPIO_D - 16;

    localparam logic [OP_W-1:0]  OP_LOAD   = 4'h0;
    localparam logic [OP_W-1:0]  OP_CONFIG = 4'h5;
    localparam logic [OP_W-1:0]  OP_START  = 4'hA;
    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(M_LEN);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        LOAD = 4'b0010,
        RUN  = 4'b0100,
        READ = 4'b1000
    } state_t;

    state_t state_q, state_d;

    logic [GPIO_D-1:0]     gpio_q;
    logic [OP_W-1:0]       op_prev_q;
    logic                  stb_prev_q;
    logic [TGT_W-1:0]      tgt_q;
    logic [M_LEN-1:0]      we_q;
    logic [NB_ADDRESS-1:0] wr_cnt_q;
    logic [BIT_LEN-1:0]    wr_data_q;
    logic [NB_IMAGE-1:0]   img_len_q;
    logic                  conv_start_q;
    logic [NB_ADDRESS-1:0] rd_addr_q;
    logic                  rd_pend_q;
    logic [BIT_LEN-1:0]    rd_data_q;
    logic                  rd_tgl_q;
    logic                  full_q;
    logic                  err_q;

    // Command field decode from the registered GPIO word
    logic [OP_W-1:0]     opcode;
    logic                stb;
    logic [SEL_W-1:0]    sel;
    logic [NB_IMAGE-1:0] payload;
    logic [BIT_LEN-1:0]  pixel;
    logic                op_event;
    logic                stb_event;
    logic                cfg;
    logic                sel_valid;
    logic                unused_bits;

    assign opcode      = gpio_q[3:0];
    assign stb         = gpio_q[4];
    assign sel         = gpio_q[7:5];
    assign payload     = gpio_q[8 +: NB_IMAGE];
    assign pixel       = gpio_q[8 +: BIT_LEN];
    assign unused_bits = ^gpio_q[GPIO_D-1:8+NB_IMAGE];

    // An opcode change in the same cycle swallows a strobe edge
    assign op_event  = (opcode != op_prev_q);
    assign stb_event = stb & ~stb_prev_q & ~op_event;
    assign cfg       = (opcode == OP_CONFIG);
    assign sel_valid = (sel != '0) && (sel <= SEL_MAX);

    logic enter_load, load_exit, retarget;
    logic wr_go, wr_commit, wr_last;
    logic start_go, start_err;
    logic done_go, rd_req, rd_commit, rd_last;

    assign wr_last = (wr_cnt_q == NB_ADDRESS'(img_len_q - NB_IMAGE'(1)));
    assign rd_last = (rd_addr_q == NB_ADDRESS'(img_len_q - NB_IMAGE'(1)));

    // State register
    always_ff @(posedge CLK100MHZ) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; CONFIG overrides every state
    always_comb begin
        state_d = state_q;
        if (cfg) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_go)        state_d = RUN;
                    else if (enter_load) state_d = LOAD;
                end
                LOAD: if (load_exit)              state_d = IDLE;
                RUN:  if (done_go)                state_d = READ;
                READ: if (rd_commit && rd_last)   state_d = IDLE;
                default:                          state_d = IDLE;
            endcase
        end
    end

    // Per-state control decode feeding the datapath registers
    always_comb begin
        enter_load = 1'b0;
        load_exit  = 1'b0;
        retarget   = 1'b0;
        wr_go      = 1'b0;
        wr_commit  = 1'b0;
        start_go   = 1'b0;
        start_err  = 1'b0;
        done_go    = 1'b0;
        rd_req     = 1'b0;
        rd_commit  = 1'b0;
        if (!cfg) begin
            case (state_q)
                IDLE: begin
                    enter_load = (opcode == OP_LOAD) && sel_valid;
                    if (op_event && (opcode == OP_START)) begin
                        start_go  = (img_len_q >= NB_IMAGE'(M_LEN));
                        start_err = (img_len_q <  NB_IMAGE'(M_LEN));
                    end
                end
                LOAD: begin
                    load_exit = (sel == '0);
                    retarget  = sel_valid && (sel != (SEL_W'(tgt_q) + SEL_W'(1)));
                    wr_go     = stb_event && !load_exit && !retarget;
                    wr_commit = (we_q != '0);
                end
                RUN: done_go = i_conv_done;
                READ: begin
                    rd_req    = stb_event && !rd_pend_q;
                    rd_commit = rd_pend_q;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge CLK100MHZ) begin
        if (i_rst) begin
            gpio_q       <= '0;
            op_prev_q    <= '0;
            stb_prev_q   <= 1'b0;
            tgt_q        <= '0;
            we_q         <= '0;
            wr_cnt_q     <= '0;
            wr_data_q    <= '0;
            img_len_q    <= '0;
            conv_start_q <= 1'b0;
            rd_addr_q    <= '0;
            rd_pend_q    <= 1'b0;
            rd_data_q    <= '0;
            rd_tgl_q     <= 1'b0;
            full_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            gpio_q       <= i_gpio;
            op_prev_q    <= opcode;
            stb_prev_q   <= stb;
            we_q         <= '0;
            conv_start_q <= start_go;
            if (cfg) begin
                img_len_q <= payload;
                wr_cnt_q  <= '0;
                rd_addr_q <= '0;
                rd_pend_q <= 1'b0;
                full_q    <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                if (start_err) err_q <= 1'b1;
                if (enter_load || retarget) begin
                    tgt_q    <= TGT_W'(sel - SEL_W'(1));
                    wr_cnt_q <= '0;
                end
                if (retarget) begin
                    full_q <= 1'b0;
                end else if (wr_commit) begin
                    if (wr_last) begin
                        wr_cnt_q <= '0;
                        full_q   <= 1'b1;
                    end else begin
                        wr_cnt_q <= wr_cnt_q + NB_ADDRESS'(1);
                    end
                end
                if (wr_go) begin
                    we_q      <= M_LEN'(1) << tgt_q;
                    wr_data_q <= pixel;
                end
                if (done_go) rd_addr_q <= '0;
                if (rd_req)  rd_pend_q <= 1'b1;
                if (rd_commit) begin
                    rd_pend_q <= 1'b0;
                    rd_data_q <= i_rd_data;
                    rd_tgl_q  <= ~rd_tgl_q;
                    rd_addr_q <= rd_addr_q + NB_ADDRESS'(1);
                end
            end
        end
    end

    assign o_led        = state_q;
    assign o_we         = we_q;
    assign o_wr_addr    = wr_cnt_q;
    assign o_wr_data    = wr_data_q;
    assign o_img_len    = img_len_q;
    assign o_conv_start = conv_start_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_gpio       = {HIGH_W'(0), rd_data_q, 1'b0, err_q, full_q, rd_tgl_q, o_led};

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameters SHALL be: BIT_LEN 8 (pixel width); NB_ADDRESS 10 (memory address width); NB_IMAGE 10 (image-length field width); M_LEN 3 (kernel size / number of line memories); GPIO_D 32 (GPIO word width).
REQ-002 One clock; reset SHALL be synchronous, active-high.
REQ-003 Ports SHALL be:
CLK100MHZ  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_gpio  in  GPIO_D  command word from processor
o_gpio  out  GPIO_D  status/readback word to processor
o_we  out  M_LEN  one-hot line-memory write enable
o_wr_addr  out  NB_ADDRESS  line-memory write address
o_wr_data  out  BIT_LEN  line-memory write data
o_img_len  out  NB_IMAGE  latched image length
o_conv_start  out  1  one-cycle convolution start pulse
i_conv_done  in  1  one-cycle convolution finished pulse
o_rd_addr  out  NB_ADDRESS  result-memory read address
i_rd_data  in  BIT_LEN  result-memory data, 1-cycle read latency
o_led  out  4  one-hot state indicator

Function
REQ-004 Command fields SHALL be: opcode i_gpio[3:0]; strobe i_gpio[4]; memory select i_gpio[7:5]; payload i_gpio[8+:NB_IMAGE] (length), byte i_gpio[15:8] (pixel).
REQ-005 i_gpio SHALL be registered once; an opcode event SHALL occur when the registered opcode differs from its previous value; a strobe event SHALL occur on a 0->1 transition of the registered strobe.
REQ-006 States SHALL be IDLE, LOAD, RUN, READ; o_led = {READ,RUN,LOAD,IDLE} one-hot.
REQ-007 Opcode 0x5 (CONFIG), while held, in any state: next state IDLE, o_img_len <= payload every cycle, write/read counters <= 0, error flag cleared; aborts LOAD/RUN/READ.
REQ-008 IDLE, opcode 0x0, select 1..3: go to LOAD targeting memory (select-1); write counter <= 0.
REQ-009 LOAD: each strobe event SHALL assert o_we[select-1] for exactly one cycle, 1 cycle after the event is registered, with o_wr_data = byte and o_wr_addr = counter; counter increments after the write.
REQ-010 LOAD: write counter reaching o_img_len-1 and being written SHALL set full flag and wrap counter to 0; further strobes overwrite from address 0.
REQ-011 LOAD: select change to another nonzero value SHALL retarget and clear counter and full flag; select 0 SHALL return to IDLE.
REQ-012 IDLE, opcode event to 0xA (START): if o_img_len >= M_LEN, pulse o_conv_start one cycle and go to RUN; otherwise stay IDLE, set error flag, no pulse.
REQ-013 RUN: strobes and opcodes other than 0x5 SHALL be ignored; i_conv_done SHALL go to READ with o_rd_addr = 0.
REQ-014 READ: each strobe event SHALL latch i_rd_data (for current o_rd_addr) into o_gpio[15:8] two cycles after the event is registered, toggle o_gpio[4], then increment o_rd_addr; after the read with o_rd_addr = o_img_len-1 go to IDLE.
REQ-015 o_gpio SHALL be: [3:0] = o_led; [4] read-valid toggle; [5] full flag; [6] error flag; [7] 0; [15:8] read data; [31:16] 0.
REQ-016 Opcode event and strobe event in same cycle: opcode SHALL be processed, strobe dropped.
REQ-017 i_conv_done outside RUN SHALL be ignored.

Reset
REQ-018 On i_rst: state IDLE, o_led 4'b0001, all other outputs, counters, flags, o_img_len 0; registered i_gpio <= 0.
REQ-019 A strobe held high through reset release SHALL produce one strobe event.

Verification
REQ-020 i_gpio 0x5 then 0xA05 then 0x0 -> o_img_len 10, state IDLE, o_gpio[6:5] = 0.
REQ-021 Len 10, i_gpio 0x20 then 10 pulses 0x07f30/0x07f20 -> o_we 3'b001 ten single pulses, addr 0..9, data 0x7f, full flag set, addr wraps to 0.
REQ-022 Len 10, 0xA -> one o_conv_start pulse, RUN; i_conv_done -> READ, o_rd_addr 0.
REQ-023 READ, 10 strobes 0x10/0x0, RAM returns addr+1 -> o_gpio[15:8] 1..10, o_gpio[4] toggles 10 times, then IDLE.
REQ-024 Len 2, 0xA -> no o_conv_start, error flag 1; then 0x5 -> error 0.
REQ-025 0x5 during RUN and during LOAD -> IDLE next cycle, counters 0, no o_we.
